alu_exec_wb: RTL and testbench
==============================

# alu_exec_wb

Execute/writeback stage of the MIPS ALU datapath. It sits directly downstream of the register file and ALU controller. It accepts one operation (operands A/B, the 4-bit ALU control code and the destination register), computes the result over a three-state sequence, and drives the register-file write port (WriteData, WriteAddr, RegWrite) for exactly one cycle. It also produces Zero/Overflow/IllegalOp status flags and a retired-operation counter.

## Interface
Parameters
- WIDTH, 32, datapath width
- CNT_WIDTH, 16, width of the retired-operation counter

Ports
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  reset; synchronous, active-low
- IssueValid  in  1  an operation is presented on A/B/ALUCtl/WriteReg
- IssueReady  out  1  stage can accept; `(state==IDLE) && RESET`
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt
- ALUCtl  in  4  ALU control code from the ALU controller
- WriteReg  in  5  destination register index
- WriteData  out  WIDTH  result to register file
- WriteAddr  out  5  destination index to register file
- RegWrite  out  1  register-file write enable, one-cycle pulse
- Zero  out  1  result == 0
- Overflow  out  1  signed overflow on ADD/SUB
- IllegalOp  out  1  ALUCtl not in the supported set
- OpCount  out  CNT_WIDTH  completed operations, wraps

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - IssueReady=1.
  - On an edge with IssueValid=1, capture A, B, ALUCtl and WriteReg into internal operand registers, then go to EXEC.
  - With IssueValid=0, stay in IDLE.
- EXEC:
  - At the edge, compute from the captured operands.
  - Register WriteData, WriteAddr, Zero, Overflow, IllegalOp, and the write-permit into RegWrite.
  - Go to WB.
- WB:
  - RegWrite is valid for this cycle only.
  - At the edge: RegWrite←0, OpCount←OpCount+1 (mod 2^CNT_WIDTH), go to IDLE.
- ALUCtl decoding:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 6 SUB (A−B)
  - 7 SLT: result 1 if signed A < signed B, else 0
  - 12 NOR
  - Any other code (including 15): IllegalOp=1, WriteData=0, RegWrite=0.
- Arithmetic:
  - Two's-complement, WIDTH bits; the result wraps.
  - Overflow=1 when the operand signs make signed overflow possible and the result sign differs:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operands have different signs and the result sign differs from A.
  - Overflow is 0 for all other ops.
- RegWrite permit: RegWrite=1 in WB only if all of the following hold:
  - the op is legal,
  - Overflow=0,
  - WriteAddr≠0.
  - Register 0 is never written.
- Zero reflects the wrapped WriteData, including when the write is suppressed.
- WriteData, WriteAddr, Zero, Overflow and IllegalOp hold their values from the EXEC edge until the next EXEC edge.
- Inputs are ignored outside the IDLE capture edge. Changes on A/B during EXEC/WB have no effect.
- OpCount counts every op that reaches WB, including suppressed and illegal ones.

## Timing
- Reset: on an edge with RESET=0, the following are cleared:
  - state←IDLE
  - WriteData←0, WriteAddr←0
  - RegWrite, Zero, Overflow, IllegalOp←0
  - OpCount←0
  - While RESET=0, IssueReady=0.
- Reset mid-operation (in EXEC or WB): the operation is aborted. No RegWrite pulse, no OpCount increment.
- Latency, for an op accepted at edge N:
  - result registered at edge N+1,
  - RegWrite high during cycle N+1→N+2,
  - IssueReady high again after edge N+2.
- Throughput: one op per 3 cycles. With IssueValid held high, ops are accepted at edges N, N+3, N+6, …
- Handshake: a transfer occurs only on an edge where IssueValid=1 and IssueReady=1. IssueValid may be deasserted at any time without effect.
- All outputs are registered except IssueReady, which is combinational from state and RESET.

## Test plan
- ADD: A=5, B=7, ALUCtl=2, WriteReg=2. Expect in WB: WriteData=12, WriteAddr=2, RegWrite=1 for exactly one cycle, Zero=0, Overflow=0, OpCount 0→1.
- SUB overflow: A=0x80000000, B=1, ALUCtl=6, WriteReg=11. Expect WriteData=0x7FFFFFFF, Overflow=1, RegWrite=0. Then A=9, B=9, SUB. Expect WriteData=0, Zero=1, RegWrite=1.
- SLT/NOR:
  - A=0xFFFFFFFF, B=1, ALUCtl=7, WriteReg=14 → WriteData=1.
  - A=0, B=0, ALUCtl=12, WriteReg=17 → WriteData=0xFFFFFFFF.
  - Both ops write.
- Guard cases:
  - ALUCtl=15 → IllegalOp=1, WriteData=0, RegWrite=0, OpCount still increments.
  - ALUCtl=0 with WriteReg=0 → RegWrite=0.
- Back-to-back: hold IssueValid=1 with 4 distinct ops. Expect:
  - IssueReady pattern 1,0,0 repeating,
  - RegWrite pulses 3 cycles apart,
  - operands changed during EXEC ignored,
  - OpCount=4.
- Reset: assert RESET=0 during EXEC of an ADD (A=1, B=1, WriteReg=3). Expect:
  - no RegWrite,
  - all outputs 0 after the edge,
  - IssueReady=0 while in reset,
  - the next op after release completes normally.

Source files
------------

// File: rtl/alu_exec_wb_if.sv
// alu_exec_wb_if: issue and register-file writeback bundle for the execute/writeback stage
interface alu_exec_wb_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 IssueValid;
  logic                 IssueReady;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [3:0]           ALUCtl;
  logic [4:0]           WriteReg;
  logic [WIDTH-1:0]     WriteData;
  logic [4:0]           WriteAddr;
  logic                 RegWrite;
  logic                 Zero;
  logic                 Overflow;
  logic                 IllegalOp;
  logic [CNT_WIDTH-1:0] OpCount;
  modport master (
    output IssueValid, A, B, ALUCtl, WriteReg,
    input  IssueReady, WriteData, WriteAddr, RegWrite, Zero, Overflow, IllegalOp, OpCount
  );
  modport slave (
    input  IssueValid, A, B, ALUCtl, WriteReg,
    output IssueReady, WriteData, WriteAddr, RegWrite, Zero, Overflow, IllegalOp, OpCount
  );
endinterface

// File: rtl/alu_exec_wb.sv
// alu_exec_wb: three-state MIPS execute/writeback stage driving the register-file write port
module alu_exec_wb #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic         CLK,
  input logic         RESET,
  alu_exec_wb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  localparam logic [3:0] CTL_AND = 4'd0, CTL_OR = 4'd1, CTL_ADD = 4'd2,
                         CTL_SUB = 4'd6, CTL_SLT = 4'd7, CTL_NOR = 4'd12;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [3:0]           ctl_q, ctl_d;
  logic [4:0]           wr_q, wr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [4:0]           waddr_q, waddr_d;
  logic                 rw_q, rw_d, zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     sum, diff, res;
  logic                 legal, ovf, cap;
  assign sum   = a_q + b_q;
  assign diff  = a_q - b_q;
  assign legal = ctl_q inside {CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR};
  assign res   = ctl_q == CTL_AND ? a_q & b_q :
                 ctl_q == CTL_OR  ? a_q | b_q :
                 ctl_q == CTL_ADD ? sum :
                 ctl_q == CTL_SUB ? diff :
                 ctl_q == CTL_SLT ? WIDTH'($signed(a_q) < $signed(b_q)) :
                 ctl_q == CTL_NOR ? ~(a_q | b_q) : '0;
  // Overflow only when operand signs allow it and the result sign flips away from A
  assign ovf   = ctl_q == CTL_ADD ? (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]) :
                 ctl_q == CTL_SUB ? (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]) :
                 1'b0;
  assign cap   = state_q == IDLE && bus.IssueValid;
  always_comb begin
    state_d = state_q == IDLE ? (bus.IssueValid ? EXEC : IDLE) : state_q == EXEC ? WB : IDLE;
    a_d     = cap ? bus.A : a_q;
    b_d     = cap ? bus.B : b_q;
    ctl_d   = cap ? bus.ALUCtl : ctl_q;
    wr_d    = cap ? bus.WriteReg : wr_q;
    wdata_d = state_q == EXEC ? res : wdata_q;
    waddr_d = state_q == EXEC ? wr_q : waddr_q;
    zero_d  = state_q == EXEC ? res == '0 : zero_q;
    ovf_d   = state_q == EXEC ? ovf : ovf_q;
    ill_d   = state_q == EXEC ? !legal : ill_q;
    rw_d    = state_q == EXEC && legal && !ovf && wr_q != 5'd0;
    cnt_d   = state_q == WB ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      wr_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      rw_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      rw_q    <= rw_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.IssueReady = state_q == IDLE && RESET;
  assign bus.WriteData  = wdata_q;
  assign bus.WriteAddr  = waddr_q;
  assign bus.RegWrite   = rw_q;
  assign bus.Zero       = zero_q;
  assign bus.Overflow   = ovf_q;
  assign bus.IllegalOp  = ill_q;
  assign bus.OpCount    = cnt_q;
endmodule

// File: tb/tb_alu_exec_wb.sv
// tb_alu_exec_wb: directed self-checking bench for the execute/writeback stage
module tb_alu_exec_wb;
  logic clk, rst_n;
  int asserts = 0, errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] obs_wd;
  logic [4:0]  obs_wa;
  logic        obs_rw, obs_z, obs_ov, obs_il, obs_rw_exec, obs_ready_exec, obs_rw_after, obs_ready_after;
  logic [15:0] obs_cnt_wb, obs_cnt_after;

  alu_exec_wb_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();
  alu_exec_wb #(.WIDTH(32), .CNT_WIDTH(16)) dut (.CLK(clk), .RESET(rst_n), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one op, scrambles operands after acceptance, and snapshots EXEC/WB/IDLE cycles
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl, input logic [4:0] wr);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.IssueReady && n < 8) begin
      @(negedge clk);
      n++;
    end
    asserts++;
    if (n == 8) begin errors++; $display("FAIL ready_timeout got IssueReady=%b exp 1", bus.IssueReady); end
    bus.IssueValid = 1'b1; bus.A = a; bus.B = b; bus.ALUCtl = ctl; bus.WriteReg = wr;
    @(posedge clk); #1;
    bus.IssueValid = 1'b0; bus.A = ~a; bus.B = ~b + 32'd3; bus.ALUCtl = 4'd2; bus.WriteReg = ~wr;
    @(negedge clk);
    obs_ready_exec = bus.IssueReady; obs_rw_exec = bus.RegWrite;
    @(negedge clk);
    obs_wd = bus.WriteData; obs_wa = bus.WriteAddr; obs_rw = bus.RegWrite;
    obs_z = bus.Zero; obs_ov = bus.Overflow; obs_il = bus.IllegalOp; obs_cnt_wb = bus.OpCount;
    @(negedge clk);
    obs_rw_after = bus.RegWrite; obs_cnt_after = bus.OpCount; obs_ready_after = bus.IssueReady;
    exp_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.IssueValid = 1'b1; bus.A = 32'd1; bus.B = 32'd2; bus.ALUCtl = 4'd2; bus.WriteReg = 5'd1;
    repeat (2) @(negedge clk);
    asserts++; if (bus.IssueReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.IssueReady); end
    asserts++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %b exp 0", bus.RegWrite); end
    asserts++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus.WriteData); end
    asserts++; if (bus.OpCount !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.OpCount); end
    bus.IssueValid = 1'b0;
    rst_n = 1'b1;
    #1;
    asserts++; if (bus.IssueReady !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", bus.IssueReady); end
  endtask

  task automatic test_add;
    do_op(32'd5, 32'd7, 4'd2, 5'd2);
    asserts++; if (obs_ready_exec !== 1'b0) begin errors++; $display("FAIL add_ready_exec got %b exp 0", obs_ready_exec); end
    asserts++; if (obs_rw_exec !== 1'b0) begin errors++; $display("FAIL add_rw_exec got %b exp 0", obs_rw_exec); end
    asserts++; if (obs_wd !== 32'd12) begin errors++; $display("FAIL add_wdata got %h exp %h", obs_wd, 32'd12); end
    asserts++; if (obs_wa !== 5'd2) begin errors++; $display("FAIL add_waddr got %0d exp 2", obs_wa); end
    asserts++; if (obs_rw !== 1'b1) begin errors++; $display("FAIL add_regwrite got %b exp 1", obs_rw); end
    asserts++; if (obs_z !== 1'b0 || obs_ov !== 1'b0 || obs_il !== 1'b0) begin errors++; $display("FAIL add_flags got z%b o%b i%b exp 000", obs_z, obs_ov, obs_il); end
    asserts++; if (obs_cnt_wb !== 16'd0) begin errors++; $display("FAIL add_count_wb got %0d exp 0", obs_cnt_wb); end
    asserts++; if (obs_rw_after !== 1'b0) begin errors++; $display("FAIL add_rw_pulse got %b exp 0", obs_rw_after); end
    asserts++; if (obs_cnt_after !== 16'd1) begin errors++; $display("FAIL add_count got %0d exp 1", obs_cnt_after); end
    asserts++; if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL add_ready_after got %b exp 1", obs_ready_after); end
    do_op(32'h7FFF_FFFF, 32'd1, 4'd2, 5'd9);
    asserts++; if (obs_wd !== 32'h8000_0000 || obs_ov !== 1'b1) begin errors++; $display("FAIL add_ovf got %h o%b exp 80000000 o1", obs_wd, obs_ov); end
    asserts++; if (obs_rw !== 1'b0) begin errors++; $display("FAIL add_ovf_rw got %b exp 0", obs_rw); end
    do_op(32'hFFFF_FFFF, 32'd1, 4'd2, 5'd9);
    asserts++; if (obs_wd !== 32'd0 || obs_z !== 1'b1 || obs_ov !== 1'b0 || obs_rw !== 1'b1) begin errors++; $display("FAIL add_wrap got %h z%b o%b w%b exp 0 z1 o0 w1", obs_wd, obs_z, obs_ov, obs_rw); end
  endtask

  task automatic test_sub;
    do_op(32'h8000_0000, 32'd1, 4'd6, 5'd11);
    asserts++; if (obs_wd !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_ovf_wdata got %h exp 7fffffff", obs_wd); end
    asserts++; if (obs_ov !== 1'b1) begin errors++; $display("FAIL sub_ovf_flag got %b exp 1", obs_ov); end
    asserts++; if (obs_rw !== 1'b0) begin errors++; $display("FAIL sub_ovf_rw got %b exp 0", obs_rw); end
    asserts++; if (obs_cnt_after !== exp_cnt) begin errors++; $display("FAIL sub_ovf_count got %0d exp %0d", obs_cnt_after, exp_cnt); end
    do_op(32'd9, 32'd9, 4'd6, 5'd11);
    asserts++; if (obs_wd !== 32'd0 || obs_z !== 1'b1) begin errors++; $display("FAIL sub_zero got %h z%b exp 0 z1", obs_wd, obs_z); end
    asserts++; if (obs_rw !== 1'b1 || obs_ov !== 1'b0) begin errors++; $display("FAIL sub_zero_rw got w%b o%b exp w1 o0", obs_rw, obs_ov); end
    do_op(32'd3, 32'd10, 4'd6, 5'd12);
    asserts++; if (obs_wd !== 32'hFFFF_FFF9 || obs_ov !== 1'b0 || obs_rw !== 1'b1) begin errors++; $display("FAIL sub_neg got %h o%b w%b exp fffffff9 o0 w1", obs_wd, obs_ov, obs_rw); end
  endtask

  task automatic test_slt_nor;
    do_op(32'hFFFF_FFFF, 32'd1, 4'd7, 5'd14);
    asserts++; if (obs_wd !== 32'd1 || obs_rw !== 1'b1 || obs_wa !== 5'd14) begin errors++; $display("FAIL slt_lt got %h w%b a%0d exp 1 w1 a14", obs_wd, obs_rw, obs_wa); end
    do_op(32'd1, 32'hFFFF_FFFF, 4'd7, 5'd15);
    asserts++; if (obs_wd !== 32'd0 || obs_z !== 1'b1 || obs_rw !== 1'b1) begin errors++; $display("FAIL slt_ge got %h z%b w%b exp 0 z1 w1", obs_wd, obs_z, obs_rw); end
    do_op(32'd0, 32'd0, 4'd12, 5'd17);
    asserts++; if (obs_wd !== 32'hFFFF_FFFF || obs_rw !== 1'b1 || obs_z !== 1'b0) begin errors++; $display("FAIL nor got %h w%b z%b exp ffffffff w1 z0", obs_wd, obs_rw, obs_z); end
  endtask

  task automatic test_guard;
    do_op(32'd3, 32'd4, 4'd15, 5'd5);
    asserts++; if (obs_il !== 1'b1 || obs_wd !== 32'd0) begin errors++; $display("FAIL illegal got i%b %h exp i1 0", obs_il, obs_wd); end
    asserts++; if (obs_rw !== 1'b0) begin errors++; $display("FAIL illegal_rw got %b exp 0", obs_rw); end
    asserts++; if (obs_cnt_after !== exp_cnt) begin errors++; $display("FAIL illegal_count got %0d exp %0d", obs_cnt_after, exp_cnt); end
    do_op(32'd3, 32'd4, 4'd5, 5'd5);
    asserts++; if (obs_il !== 1'b1 || obs_rw !== 1'b0) begin errors++; $display("FAIL illegal5 got i%b w%b exp i1 w0", obs_il, obs_rw); end
    do_op(32'hF0, 32'h3C, 4'd0, 5'd0);
    asserts++; if (obs_wd !== 32'h30 || obs_wa !== 5'd0 || obs_il !== 1'b0) begin errors++; $display("FAIL r0_and got %h a%0d i%b exp 30 a0 i0", obs_wd, obs_wa, obs_il); end
    asserts++; if (obs_rw !== 1'b0) begin errors++; $display("FAIL r0_rw got %b exp 0", obs_rw); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] av[4] = '{32'd10, 32'hF0, 32'hFF, 32'd100};
    logic [31:0] bv[4] = '{32'd20, 32'h0F, 32'h0F, 32'd1};
    logic [3:0]  cv[4] = '{4'd2, 4'd1, 4'd0, 4'd6};
    logic [31:0] rv[4] = '{32'd30, 32'hFF, 32'h0F, 32'd99};
    logic [15:0] start;
    start = exp_cnt;
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      asserts++; if (bus.IssueReady !== (c % 3 == 0)) begin errors++; $display("FAIL b2b_ready c%0d got %b exp %b", c, bus.IssueReady, c % 3 == 0); end
      asserts++; if (bus.RegWrite !== (c % 3 == 2)) begin errors++; $display("FAIL b2b_rw c%0d got %b exp %b", c, bus.RegWrite, c % 3 == 2); end
      if (c % 3 == 2) begin
        asserts++; if (bus.WriteData !== rv[c/3] || bus.WriteAddr !== 5'(c/3 + 1)) begin errors++; $display("FAIL b2b_wdata c%0d got %h a%0d exp %h a%0d", c, bus.WriteData, bus.WriteAddr, rv[c/3], c/3 + 1); end
      end
      bus.IssueValid = 1'b1;
      bus.A = c % 3 == 0 ? av[c/3] : $urandom;
      bus.B = c % 3 == 0 ? bv[c/3] : $urandom;
      bus.ALUCtl = c % 3 == 0 ? cv[c/3] : 4'd12;
      bus.WriteReg = c % 3 == 0 ? 5'(c/3 + 1) : 5'd31;
      @(negedge clk);
    end
    bus.IssueValid = 1'b0;
    exp_cnt = start + 16'd4;
    asserts++; if (bus.OpCount !== exp_cnt) begin errors++; $display("FAIL b2b_count got %0d exp %0d", bus.OpCount, exp_cnt); end
  endtask

  task automatic test_reset_mid;
    logic saw_rw;
    saw_rw = 1'b0;
    @(negedge clk);
    bus.IssueValid = 1'b1; bus.A = 32'd1; bus.B = 32'd1; bus.ALUCtl = 4'd2; bus.WriteReg = 5'd3;
    @(posedge clk); #1;
    bus.IssueValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    asserts++; if (bus.IssueReady !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", bus.IssueReady); end
    repeat (3) begin
      @(negedge clk);
      saw_rw |= bus.RegWrite;
    end
    asserts++; if (bus.WriteData !== 32'd0 || bus.WriteAddr !== 5'd0) begin errors++; $display("FAIL mid_data got %h a%0d exp 0 a0", bus.WriteData, bus.WriteAddr); end
    asserts++; if (bus.Zero !== 1'b0 || bus.Overflow !== 1'b0 || bus.IllegalOp !== 1'b0) begin errors++; $display("FAIL mid_flags got z%b o%b i%b exp 000", bus.Zero, bus.Overflow, bus.IllegalOp); end
    asserts++; if (bus.OpCount !== 16'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.OpCount); end
    asserts++; if (bus.IssueReady !== 1'b0) begin errors++; $display("FAIL mid_ready_hold got %b exp 0", bus.IssueReady); end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      saw_rw |= bus.RegWrite;
    end
    asserts++; if (saw_rw !== 1'b0) begin errors++; $display("FAIL mid_no_write got %b exp 0", saw_rw); end
    asserts++; if (bus.OpCount !== 16'd0) begin errors++; $display("FAIL mid_no_count got %0d exp 0", bus.OpCount); end
    exp_cnt = '0;
    do_op(32'd2, 32'd3, 4'd2, 5'd3);
    asserts++; if (obs_wd !== 32'd5 || obs_rw !== 1'b1 || obs_wa !== 5'd3) begin errors++; $display("FAIL post_rst_op got %h w%b a%0d exp 5 w1 a3", obs_wd, obs_rw, obs_wa); end
    asserts++; if (obs_cnt_after !== 16'd1) begin errors++; $display("FAIL post_rst_count got %0d exp 1", obs_cnt_after); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.IssueValid = 1'b0; bus.A = '0; bus.B = '0; bus.ALUCtl = '0; bus.WriteReg = '0;
    test_reset;
    test_add;
    test_sub;
    test_slt_nor;
    test_guard;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end
endmodule
